// File: rtl/mult_operand_ctrl.sv
// Operand entry sequencer for the multiplier: captures A then B from the switches, pulses start, latches the product.
// Latency: button rise acts on the next clk; mult_start follows a go rise by one cycle; result updates one cycle after mult_done.
module mult_operand_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_load,
  input  logic                 btn_go,
  input  logic                 btn_clr,
  input  logic [WIDTH-1:0]     switches,
  input  logic                 mult_done,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  output logic                 mult_start,
  output logic [2*WIDTH-1:0]   result,
  output logic [2:0]           state
);

  localparam logic [2:0] S_A     = 3'd0;
  localparam logic [2:0] S_B     = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_SHOW  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               start_q, start_d;
  logic               load_prev_q, go_prev_q, clr_prev_q;
  logic               load_rise, go_rise, clr_rise;

  // History resets high so a button already held when reset releases gives no edge.
  assign load_rise = btn_load & ~load_prev_q;
  assign go_rise   = btn_go   & ~go_prev_q;
  assign clr_rise  = btn_clr  & ~clr_prev_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    start_d  = 1'b0;
    case (state_q)
      // The multiplier cannot be aborted, so every button is dropped here.
      S_BUSY: begin
        if (mult_done) begin
          result_d = mult_product;
          state_d  = S_SHOW;
        end
      end
      S_A, S_B, S_READY, S_SHOW: begin
        if (clr_rise) begin
          a_d      = '0;
          b_d      = '0;
          result_d = '0;
          state_d  = S_A;
        end else begin
          case (state_q)
            S_A: begin
              if (load_rise) begin
                a_d     = switches;
                state_d = S_B;
              end
            end
            S_B: begin
              if (load_rise) begin
                b_d     = switches;
                state_d = S_READY;
              end
            end
            S_READY: begin
              if (go_rise) begin
                start_d = 1'b1;
                state_d = S_BUSY;
              end
            end
            S_SHOW: begin
              if (load_rise) begin
                a_d     = switches;
                state_d = S_B;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      start_q     <= 1'b0;
      load_prev_q <= 1'b1;
      go_prev_q   <= 1'b1;
      clr_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      start_q     <= start_d;
      load_prev_q <= btn_load;
      go_prev_q   <= btn_go;
      clr_prev_q  <= btn_clr;
    end
  end

  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign mult_start = start_q;
  assign result     = result_q;
  assign state      = state_q;

endmodule

// File: doc/mult_operand_ctrl.md
Name: mult_operand_ctrl

Overview:
- Consumes the debounced push-button levels produced by the debouncer stage, plus the raw operand switch bank.
- Sequences operand entry (A, then B), launches the multiplier with a one-cycle start pulse and waits for its done signal.
- Latches the product into a result register for the display stage.
- Sits between the debouncers and the multiplier core, in the same clock domain as the debouncers.

Parameters:
- WIDTH, 8, operand width in bits; product and result are 2*WIDTH bits.

Ports:
- clk  input  1  system clock; the same clock that drives the debouncers.
- rst_n  input  1  asynchronous active-low reset.
- btn_load  input  1  debounced level; a rising edge captures switches as the next operand.
- btn_go  input  1  debounced level; a rising edge starts a multiply.
- btn_clr  input  1  debounced level; a rising edge clears everything.
- switches  input  WIDTH  operand value from the board switches.
- mult_done  input  1  multiplier completion strobe, high for at least 1 cycle.
- mult_product  input  2*WIDTH  multiplier result, valid while mult_done=1.
- mult_a  output  WIDTH  operand A register, driven continuously.
- mult_b  output  WIDTH  operand B register, driven continuously.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- result  output  2*WIDTH  held product for display.
- state  output  3  FSM state for LEDs: S_A=0, S_B=1, S_READY=2, S_BUSY=3, S_SHOW=4.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=S_A; mult_a, mult_b, result=0; mult_start=0.
  - Edge-detect history registers reset to 1, so a button already held at reset release produces no edge.
- Edge detection: a rise occurs when the current level=1 and the previous-cycle level=0. A rise is seen for exactly one cycle per press, and it is consumed in that cycle whether or not the current state acts on it.
- Rise priority within a cycle: clr > load > go. Only the highest-priority rise that is meaningful in the current state acts; the others are discarded.
- All register updates and state changes occur one clk after the rise cycle.
- S_A:
  - load rise: mult_a<=switches; go to S_B.
  - go rise: ignored.
- S_B:
  - load rise: mult_b<=switches; go to S_READY.
  - go rise: ignored.
- S_READY:
  - go rise: go to S_BUSY; mult_start=1 for exactly the first S_BUSY cycle, 0 otherwise.
  - load rise: ignored; operands are locked.
- S_BUSY:
  - mult_done=1 in any S_BUSY cycle, including the start-pulse cycle: result<=mult_product; go to S_SHOW.
  - All buttons are ignored, including clr; the multiplier cannot be aborted.
  - mult_a and mult_b are held stable for the whole operation.
- S_SHOW:
  - result is held.
  - load rise: mult_a<=switches; go to S_B, which starts a new entry and keeps the old result visible until the next done.
  - go rise: ignored.
- clr rise in any state except S_BUSY: mult_a, mult_b, result<=0; go to S_A.
- mult_done outside S_BUSY is ignored; result does not change.
- Multiplier handshake latency: go rise at cycle n gives mult_start=1 at n+1. Result updates one cycle after the first mult_done in S_BUSY.
- switches is sampled only in the capture cycle. Later switch changes do not affect mult_a or mult_b.
- No illegal-state lockup: state encodings 5-7 return to S_A on the next clk.

Test Plan:
- Reset with btn_load held high, release rst_n, keep load high 10 cycles -> state stays 0, mult_a=0 (no spurious edge).
- Load with switches=8'h0C, load with switches=8'h0D, go, model mult_done 4 cycles after mult_start with product 16'h009C -> mult_start high exactly 1 cycle; mult_a=0C and mult_b=0D stable throughout; result=009C; state=4.
- In S_BUSY, press clr and load, then mult_done -> state goes to S_SHOW, result updates, operands unchanged.
- Same-cycle rise of clr and load in S_B with switches=8'hFF -> state=0, mult_a=mult_b=0, 8'hFF not captured.
- From S_SHOW (result=16'hFE01), load with switches=8'h03 -> state=1, mult_a=03, result still FE01.
- Assert rst_n=0 mid-S_BUSY -> all outputs 0 immediately (asynchronously), state=0; a later stray mult_done has no effect.
